// File: rtl/tdm_demux16.sv
// 1-to-16 TDM demultiplexer: manual per-word channel select or auto frame fill
// with a shadow buffer that publishes all 16 channels in one update.
module tdm_demux16 #(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     din,
  input  logic [3:0]           sel,
  input  logic                 auto_mode,
  input  logic                 abort,
  output logic [16*WIDTH-1:0]  out_bus,
  output logic [15:0]          out_strobe,
  output logic                 frame_done,
  output logic [7:0]           frame_cnt,
  output logic [3:0]           cur_ch
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state;
  logic [16*WIDTH-1:0] shadow;
  logic                accept;

  // DONE is the single publish cycle; stalling input there keeps shadow stable.
  assign in_ready = (state != DONE);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      out_bus    <= '0;
      out_strobe <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      cur_ch     <= '0;
      shadow     <= '0;
    end else begin
      out_strobe <= '0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            out_bus[int'(sel)*WIDTH +: WIDTH] <= din;
            out_strobe                        <= 16'd1 << sel;
          end else if (auto_mode) begin
            state  <= SCAN;
            cur_ch <= 4'd0;
          end
        end
        SCAN: begin
          if (abort) begin
            state  <= IDLE;
            cur_ch <= 4'd0;
          end else if (accept) begin
            shadow[int'(cur_ch)*WIDTH +: WIDTH] <= din;
            cur_ch                              <= cur_ch + 4'd1;
            if (cur_ch == 4'd15) state <= DONE;
          end
        end
        DONE: begin
          out_bus    <= shadow;
          out_strobe <= 16'hFFFF;
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
          state      <= auto_mode ? SCAN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
